// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 encryptor: run-time key length, one key-schedule
// word per cycle into a round-key store, then one cipher round per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its data until that edge.
module aes_iter_cipher #(
    parameter int MAX_NK = 8,
    parameter int MAX_NR = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key,
    output logic                  key_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out
);

    localparam int NW = 4 * (MAX_NR + 1);

    if (!((MAX_NK == 4 || MAX_NK == 6 || MAX_NK == 8) && MAX_NR == MAX_NK + 6)) begin : g_param_check
        $fatal(1, "aes_iter_cipher: MAX_NK must be 4/6/8 and MAX_NR must be MAX_NK+6");
    end

    typedef enum logic [2:0] {S_NOKEY, S_KEYEXP, S_READY, S_ROUND, S_DONE} state_t;

    state_t        r_fsm;
    logic [31:0]   r_w [NW];
    logic [5:0]    r_widx;
    logic [2:0]    r_kmod;
    logic [3:0]    r_nk;
    logic [3:0]    r_nr;
    logic [3:0]    r_round;
    logic [7:0]    r_rcon;
    logic [127:0]  r_st;
    logic [127:0]  r_out;
    logic          r_out_valid;
    logic          r_key_err;
    logic          r_key_loaded;

    logic          w_len_ok;
    logic          w_key_acc;
    logic          w_blk_acc;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sw_in;
    logic [31:0]   w_sw;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;
    logic [127:0]  w_rk;
    logic [127:0]  w_rk0;
    logic [127:0]  w_sr;
    logic [127:0]  w_mc;
    logic [127:0]  w_next;
    logic [3:0]    w_len_nk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) plus affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
        r = gmul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Lengths above the elaborated maximum are refused like the reserved code.
    assign w_len_ok  = (key_len == 2'd0) || (key_len == 2'd1 && MAX_NK >= 6) ||
                       (key_len == 2'd2 && MAX_NK >= 8);
    assign w_len_nk  = 4'd4 + {1'b0, key_len, 1'b0};

    // A block offered in READY wins over a key offered in the same cycle.
    assign key_ready = (r_fsm == S_NOKEY) || (r_fsm == S_READY && !in_valid);
    assign in_ready  = (r_fsm == S_READY && r_key_loaded) || (r_fsm == S_DONE && out_ready);
    assign w_key_acc = key_valid && key_ready;
    assign w_blk_acc = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign key_err   = r_key_err;

    // Key schedule word i from w[i-1] and w[i-Nk]; one shared SubWord.
    assign w_prev  = r_w[r_widx - 6'd1];
    assign w_back  = r_w[r_widx - {2'b00, r_nk}];
    assign w_sw_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sw    = {sbox(w_sw_in[31:24]), sbox(w_sw_in[23:16]),
                      sbox(w_sw_in[15:8]),  sbox(w_sw_in[7:0])};
    assign w_temp  = (r_kmod == 3'd0) ? (w_sw ^ {r_rcon, 24'h0}) :
                     (r_nk == 4'd8 && r_kmod == 3'd4) ? w_sw : w_prev;
    assign w_new   = w_back ^ w_temp;

    assign w_rk0 = {r_w[0], r_w[1], r_w[2], r_w[3]};
    assign w_rk  = {r_w[{r_round, 2'b00}], r_w[{r_round, 2'b01}],
                    r_w[{r_round, 2'b10}], r_w[{r_round, 2'b11}]};

    // Round datapath: SubBytes+ShiftRows fused, then MixColumns per column.
    always_comb begin
        w_sr = '0;
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = sbox(r_st[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
    end

    assign w_next = (r_round == r_nr) ? (w_sr ^ w_rk) : (w_mc ^ w_rk);

    // Round-key store: raw key words on accept, then one expanded word per cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_key_acc && w_len_ok) begin
            for (int j = 0; j < MAX_NK; j++) r_w[j] <= key[32*MAX_NK-1-32*j -: 32];
        end else if (!rst && r_fsm == S_KEYEXP) begin
            r_w[r_widx] <= w_new;
        end
    end

    // Control FSM with expansion counters, round counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= S_NOKEY;
            r_key_loaded <= 1'b0;
            r_round      <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_key_err    <= 1'b0;
            r_widx       <= '0;
            r_kmod       <= '0;
            r_nk         <= 4'd4;
            r_nr         <= 4'd10;
            r_rcon       <= 8'h01;
            r_st         <= '0;
        end else begin
            r_key_err <= 1'b0;
            case (r_fsm)
                S_NOKEY, S_READY: begin
                    if (w_blk_acc) begin
                        r_st    <= in ^ w_rk0;
                        r_round <= 4'd1;
                        r_fsm   <= S_ROUND;
                    end else if (w_key_acc) begin
                        if (w_len_ok) begin
                            r_nk         <= w_len_nk;
                            r_nr         <= w_len_nk + 4'd6;
                            r_widx       <= {2'b00, w_len_nk};
                            r_kmod       <= '0;
                            r_rcon       <= 8'h01;
                            r_key_loaded <= 1'b0;
                            r_fsm        <= S_KEYEXP;
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end
                end
                S_KEYEXP: begin
                    if (r_widx == {r_nr, 2'b11}) begin
                        r_key_loaded <= 1'b1;
                        r_fsm        <= S_READY;
                    end else begin
                        r_widx <= r_widx + 6'd1;
                    end
                    if ({1'b0, r_kmod} == r_nk - 4'd1) r_kmod <= '0;
                    else                                r_kmod <= r_kmod + 3'd1;
                    if (r_kmod == 3'd0) r_rcon <= xt(r_rcon);
                end
                S_ROUND: begin
                    r_st <= w_next;
                    if (r_round == r_nr) begin
                        r_out       <= w_next;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_blk_acc) begin
                            r_st    <= in ^ w_rk0;
                            r_round <= 4'd1;
                            r_fsm   <= S_ROUND;
                        end else begin
                            r_fsm <= S_READY;
                        end
                    end
                end
                default: r_fsm <= S_NOKEY;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: FIPS-197 vectors, timing, backpressure,
// streaming, illegal key, block/key priority and mid-block reset.
module tb_aes_iter_cipher;
  localparam int MAX_NK = 8;
  localparam int MAX_NR = 14;

  localparam logic [255:0] KB    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KC128 = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] KC192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hfeedfacebadc0ffe};
  localparam logic [255:0] KC256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C2    = 128'h8ea2b7ca516745bfeafc49904b496089;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 key_valid = 1'b0;
  logic                 key_ready;
  logic [1:0]           key_len = 2'd0;
  logic [32*MAX_NK-1:0] key = '0;
  logic                 key_err;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [127:0]         din = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [127:0]         dout;

  aes_iter_cipher #(.MAX_NK(MAX_NK), .MAX_NR(MAX_NR)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_len(key_len), .key(key), .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  int n_vec = 0;
  int n_err = 0;
  int last_out_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops on every output handshake (it completes at the next rising edge)
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      last_out_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected nothing", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ciphertext", dout, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin n_vec++; n_err++; $display("FAIL in_ready_timeout: got 0 expected 1"); end
  endtask

  task automatic wait_out_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check(name, n, exp_lat);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic load_key(input logic [1:0] len, input logic [255:0] k, input int exp_cycles);
    int n;
    n = 0;
    while (!key_ready && n < 200) begin tick(); n++; end
    key_valid = 1'b1;
    key_len   = len;
    key       = k;
    tick();
    key_valid = 1'b0;
    key       = '1;
    n = 0;
    while (!key_ready && n < 200) begin tick(); n++; end
    check("key_expansion_cycles", n, exp_cycles);
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] ct, input int exp_lat);
    wait_in_ready();
    in_valid = 1'b1;
    din      = pt;
    tick();
    exp_q.push_back(ct);
    in_valid = 1'b0;
    din      = '1;
    wait_out_valid("latency", exp_lat);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int start;
    int n;
    logic hs;

    // reset values
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out", dout, 0);
    check("rst_key_err", key_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_key_ready", key_ready, 1);
    rst = 1'b0;
    tick();

    // App. B and App. C vectors
    load_key(2'd0, KB, 40);
    send_block(PB, CB, 10);
    load_key(2'd0, KC128, 40);
    send_block(PC, C0, 10);
    load_key(2'd1, KC192, 46);
    send_block(PC, C1, 12);
    load_key(2'd2, KC256, 52);
    send_block(PC, C2, 14);

    // backpressure: output held 20 cycles
    out_ready = 1'b0;
    wait_in_ready();
    in_valid = 1'b1;
    din      = PC;
    tick();
    exp_q.push_back(C2);
    in_valid = 1'b0;
    wait_out_valid("stall_latency", 14);
    for (int i = 0; i < 20; i++) begin
      check("stall_out", dout, C2);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    // release with a new block in the same cycle
    in_valid  = 1'b1;
    din       = PC;
    out_ready = 1'b1;
    #1;
    check("same_cycle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    exp_q.push_back(C2);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("after_release_out_valid", out_valid, 0);
    wait_out_valid("back_to_back_latency", 14);
    check("one_outstanding", exp_q.size(), 1);
    out_ready = 1'b1;
    wait_drain();

    // streaming four 128-bit blocks
    load_key(2'd0, KC128, 40);
    in_valid = 1'b1;
    din      = PC;
    got = 0;
    start = 0;
    n = 0;
    while (got < 4 && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
      if (hs) begin
        if (got == 0) start = cyc;
        exp_q.push_back(C0);
        got++;
        if (got == 4) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_accepts", got, 4);
    wait_drain();
    check("stream_cycles", last_out_cyc - start, 44);

    // illegal key keeps the loaded one
    load_key(2'd0, KB, 40);
    key_valid = 1'b1;
    key_len   = 2'd3;
    key       = KC256;
    tick();
    key_valid = 1'b0;
    check("illegal_key_err", key_err, 1);
    check("illegal_key_ready", key_ready, 1);
    check("illegal_in_ready", in_ready, 1);
    tick();
    check("illegal_key_err_pulse", key_err, 0);
    send_block(PB, CB, 10);

    // simultaneous key and block in READY: block wins
    key_valid = 1'b1;
    key_len   = 2'd0;
    key       = KC128;
    in_valid  = 1'b1;
    din       = PB;
    #1;
    check("priority_key_ready", key_ready, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(CB);
    key_valid = 1'b0;
    in_valid  = 1'b0;
    wait_out_valid("priority_latency", 10);
    wait_drain();

    // reset in the middle of a block
    wait_in_ready();
    in_valid = 1'b1;
    din      = PB;
    tick();
    exp_q.push_back(CB);
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", dout, 0);
    check("midrst_key_err", key_err, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_key_ready", key_ready, 1);
    exp_q.delete();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 0);
    load_key(2'd2, KC256, 52);
    send_block(PC, C2, 14);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
